// File: rtl/sync_ram_pkg.sv
// Shared types and helpers for the dual-port trie lookup RAM.
// Holds the FSM state encoding and the byte-enable mask expansion.
package sync_ram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int MAXB = 16;
  localparam int MAXW = 8 * MAXB;

  function automatic logic [MAXW-1:0] be_mask(
    input logic [MAXB-1:0] be
  );
    logic [MAXW-1:0] m;
    for (int i = 0; i < MAXB; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read result output pipeline, LAT stages deep.
// Data stages only load on a valid beat so dataOut holds between reads.
module ram_rd_pipe #(
  parameter int DAT = 32,
  parameter int LAT = 1
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           inValid,
  input  logic [DAT-1:0] inData,
  output logic           outValid,
  output logic [DAT-1:0] outData
);

  logic [LAT-1:0] v;
  logic [DAT-1:0] d [LAT];

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      v <= '0;
      for (int i = 0; i < LAT; i++) begin
        d[i] <= '0;
      end
    end else begin
      v[0] <= inValid;
      if (inValid) begin
        d[0] <= inData;
      end
      for (int i = 1; i < LAT; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) begin
          d[i] <= d[i-1];
        end
      end
    end
  end

  assign outValid = v[LAT-1];
  assign outData  = d[LAT-1];

endmodule

// File: rtl/sync_ram_dp.sv
// Simple dual-port synchronous RAM with byte enables, write-first
// collision forwarding, post-reset clearing sweep and sticky range error.
module sync_ram_dp
  import sync_ram_pkg::*;
#(
  parameter int ADR    = 8,
  parameter int DAT    = 32,
  parameter int DPTH   = 192,
  parameter int RD_LAT = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             CS,
  input  logic             WE,
  input  logic [ADR-1:0]   WAddr,
  input  logic [DAT-1:0]   dataIn,
  input  logic [DAT/8-1:0] BE,
  input  logic             RD,
  input  logic [ADR-1:0]   RAddr,
  output logic [DAT-1:0]   dataOut,
  output logic             dataValid,
  output logic             Busy,
  output logic             Err
);

  localparam int NB = DAT / 8;
  localparam logic [ADR:0] DEPTH = (ADR+1)'(DPTH);
  localparam logic [ADR-1:0] LAST = ADR'(DPTH - 1);

  if (DAT % 8 != 0 || DAT > MAXW) begin : g_dat_chk
    $error("sync_ram_dp: DAT must be a multiple of 8");
  end
  if (DPTH < 1 || DPTH > (1 << ADR)) begin : g_dpth_chk
    $error("sync_ram_dp: DPTH must be in 1..2**ADR");
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_lat_chk
    $error("sync_ram_dp: RD_LAT must be 1 or 2");
  end

  state_t         st_q, st_d;
  logic [ADR-1:0] cnt_q, cnt_d;
  logic [DAT-1:0] mem [DPTH];

  logic            ready;
  logic            w_in, r_in;
  logic            wr_acc, rd_acc;
  logic [MAXB-1:0] be_ext;
  logic [MAXW-1:0] mask_w;
  logic [DAT-1:0]  wmask;
  logic [DAT-1:0]  wold, wnew, rdata;
  logic            rd_v;
  logic [DAT-1:0]  rd_d;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      st_q  <= INIT;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    unique case (st_q)
      INIT: begin
        cnt_d = cnt_q + ADR'(1);
        if (cnt_q == LAST) begin
          st_d  = READY;
          cnt_d = '0;
        end
      end
      READY: ;
      default: st_d = INIT;
    endcase
  end

  assign ready  = (st_q == READY);
  assign Busy   = (st_q == INIT);
  assign w_in   = {1'b0, WAddr} < DEPTH;
  assign r_in   = {1'b0, RAddr} < DEPTH;
  assign wr_acc = ready & CS & WE;
  assign rd_acc = ready & CS & RD;

  always_comb begin
    be_ext = '0;
    be_ext[NB-1:0] = BE;
  end

  assign mask_w = be_mask(be_ext);
  assign wmask  = mask_w[DAT-1:0];

  if (DAT < MAXW) begin : g_mask_tail
    logic [MAXW-DAT-1:0] mask_unused;
    assign mask_unused = mask_w[MAXW-1:DAT];
  end

  assign wold = w_in ? mem[WAddr] : '0;
  assign wnew = (wold & ~wmask) | (dataIn & wmask);

  // Same-cycle write to the read address is forwarded (write-first).
  always_comb begin
    rdata = '0;
    if (r_in) begin
      if (wr_acc && w_in && RAddr == WAddr) begin
        rdata = wnew;
      end else begin
        rdata = mem[RAddr];
      end
    end
  end

  // Storage has no reset; the INIT sweep zeroes it instead.
  always_ff @(posedge Clk) begin
    if (st_q == INIT) begin
      mem[cnt_q] <= '0;
    end else if (wr_acc && w_in) begin
      mem[WAddr] <= wnew;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rd_v <= 1'b0;
      rd_d <= '0;
      Err  <= 1'b0;
    end else begin
      rd_v <= rd_acc;
      if (rd_acc) begin
        rd_d <= rdata;
      end
      Err <= Err | (wr_acc & ~w_in) | (rd_acc & ~r_in);
    end
  end

  ram_rd_pipe #(
    .DAT (DAT),
    .LAT (RD_LAT)
  ) u_pipe (
    .Clk      (Clk),
    .Rst      (Rst),
    .inValid  (rd_v),
    .inData   (rd_d),
    .outValid (dataValid),
    .outData  (dataOut)
  );

endmodule

// File: tb/tb_sync_ram_dp.sv
// Bench for sync_ram_dp: RD_LAT=1 and RD_LAT=2 instances on shared inputs,
// directed vector table plus random traffic against a word-level model.
module tb_sync_ram_dp;

  localparam int ADR  = 8;
  localparam int DAT  = 32;
  localparam int DPTH = 192;

  logic            Clk = 1'b0;
  logic            Rst;
  logic            CS, WE, RD;
  logic [ADR-1:0]  WAddr, RAddr;
  logic [DAT-1:0]  dataIn;
  logic [3:0]      BE;
  logic [DAT-1:0]  do1, do2;
  logic            dv1, dv2, busy1, busy2, err1, err2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  sync_ram_dp #(.ADR(ADR), .DAT(DAT), .DPTH(DPTH), .RD_LAT(1)) u1 (
    .Clk(Clk), .Rst(Rst), .CS(CS), .WE(WE), .WAddr(WAddr),
    .dataIn(dataIn), .BE(BE), .RD(RD), .RAddr(RAddr),
    .dataOut(do1), .dataValid(dv1), .Busy(busy1), .Err(err1)
  );

  sync_ram_dp #(.ADR(ADR), .DAT(DAT), .DPTH(DPTH), .RD_LAT(2)) u2 (
    .Clk(Clk), .Rst(Rst), .CS(CS), .WE(WE), .WAddr(WAddr),
    .dataIn(dataIn), .BE(BE), .RD(RD), .RAddr(RAddr),
    .dataOut(do2), .dataValid(dv2), .Busy(busy2), .Err(err2)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Word-level model: memory array, init countdown, per-edge read results
  logic [31:0] mmem [DPTH];
  int          init_left = DPTH;
  logic        merr = 1'b0;
  logic        m1v = 1'b0, m2v = 1'b0, e1v = 1'b0, e2v = 1'b0;
  logic [31:0] m1d = '0, m2d = '0, e1d = '0, e2d = '0;

  task automatic model_reset();
    init_left = DPTH;
    merr = 1'b0;
    m1v = 1'b0; m2v = 1'b0; e1v = 1'b0; e2v = 1'b0;
    m1d = '0;   m2d = '0;   e1d = '0;   e2d = '0;
  endtask

  task automatic model_edge();
    logic        rv;
    logic [31:0] rdat;
    rv = 1'b0;
    rdat = '0;
    if (init_left > 0) begin
      init_left--;
      if (init_left == 0) begin
        for (int a = 0; a < DPTH; a++) mmem[a] = '0;
      end
    end else begin
      if (CS && WE) begin
        if (int'(WAddr) < DPTH) begin
          for (int b = 0; b < 4; b++)
            if (BE[b]) mmem[WAddr][8*b +: 8] = dataIn[8*b +: 8];
        end else merr = 1'b1;
      end
      if (CS && RD) begin
        rv = 1'b1;
        if (int'(RAddr) < DPTH) rdat = mmem[RAddr];
        else merr = 1'b1;
      end
    end
    e1v = m1v;
    if (m1v) e1d = m1d;
    e2v = m2v;
    if (m2v) e2d = m2d;
    m2v = m1v; m2d = m1d;
    m1v = rv;  m1d = rdat;
  endtask

  always @(posedge Rst) model_reset();

  always @(posedge Clk) begin
    if (Rst) model_reset();
    else model_edge();
    #3;
    chk("m_dv1", 32'(dv1), 32'(e1v));
    chk("m_do1", do1, e1d);
    chk("m_dv2", 32'(dv2), 32'(e2v));
    chk("m_do2", do2, e2d);
    chk("m_busy", {30'd0, busy1, busy2},
        {30'd0, {2{Rst || init_left > 0}}});
    chk("m_err", {30'd0, err1, err2}, {30'd0, {2{merr}}});
  end

  typedef struct {
    logic        we;
    logic [7:0]  wa;
    logic [31:0] di;
    logic [3:0]  be;
    logic        rd;
    logic [7:0]  ra;
    logic        ev;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  vec_t tbl [20];

  task automatic sweep_zero();
    for (int a = 0; a < DPTH; a++) begin
      RAddr = 8'(a);
      RD = 1'b1;
      @(posedge Clk); #2;
    end
    RD = 1'b0;
    repeat (4) @(posedge Clk);
    #2;
    chk("sweep_do1", do1, 32'h0);
    chk("sweep_do2", do2, 32'h0);
  endtask

  initial begin
    logic        pv;
    logic [31:0] pd;

    tbl[0]  = '{1, 8'd10,  32'hAABBCCDD, 4'hF, 0, 8'd0,   0, 32'h0,        0};
    tbl[1]  = '{1, 8'd10,  32'h11223344, 4'h5, 0, 8'd0,   0, 32'h0,        0};
    tbl[2]  = '{0, 8'd0,   32'h0,        4'h0, 1, 8'd10,  0, 32'h0,        0};
    tbl[3]  = '{1, 8'd20,  32'h0,        4'hF, 0, 8'd0,   1, 32'hAA22CC44, 0};
    tbl[4]  = '{1, 8'd20,  32'hDEADBEEF, 4'hC, 1, 8'd20,  0, 32'hAA22CC44, 0};
    tbl[5]  = '{1, 8'd200, 32'h12345678, 4'hF, 0, 8'd0,   1, 32'hDEAD0000, 1};
    tbl[6]  = '{0, 8'd0,   32'h0,        4'h0, 1, 8'd200, 0, 32'hDEAD0000, 1};
    tbl[7]  = '{0, 8'd0,   32'h0,        4'h0, 1, 8'd0,   1, 32'h0,        1};
    tbl[8]  = '{0, 8'd0,   32'h0,        4'h0, 1, 8'd20,  1, 32'h0,        1};
    tbl[9]  = '{0, 8'd0,   32'h0,        4'h0, 0, 8'd0,   1, 32'hDEAD0000, 1};
    tbl[10] = '{0, 8'd0,   32'h0,        4'h0, 0, 8'd0,   0, 32'hDEAD0000, 1};
    tbl[11] = '{1, 8'd1,   32'h1,        4'hF, 0, 8'd0,   0, 32'hDEAD0000, 1};
    tbl[12] = '{1, 8'd2,   32'h2,        4'hF, 0, 8'd0,   0, 32'hDEAD0000, 1};
    tbl[13] = '{1, 8'd3,   32'h3,        4'hF, 0, 8'd0,   0, 32'hDEAD0000, 1};
    tbl[14] = '{0, 8'd0,   32'h0,        4'h0, 1, 8'd1,   0, 32'hDEAD0000, 1};
    tbl[15] = '{0, 8'd0,   32'h0,        4'h0, 1, 8'd2,   1, 32'h1,        1};
    tbl[16] = '{0, 8'd0,   32'h0,        4'h0, 1, 8'd3,   1, 32'h2,        1};
    tbl[17] = '{0, 8'd0,   32'h0,        4'h0, 0, 8'd0,   1, 32'h3,        1};
    tbl[18] = '{0, 8'd0,   32'h0,        4'h0, 0, 8'd0,   0, 32'h3,        1};
    tbl[19] = '{0, 8'd0,   32'h0,        4'h0, 0, 8'd0,   0, 32'h3,        1};

    Rst = 1'b1; CS = 1'b1; WE = 1'b1; WAddr = 8'd7;
    dataIn = 32'hFFFFFFFF; BE = 4'hF; RD = 1'b1; RAddr = 8'd5;
    #2;
    chk("rst_do1", do1, 32'h0);
    chk("rst_dv1", 32'(dv1), 32'h0);
    chk("rst_busy", 32'(busy1), 32'h1);
    repeat (3) @(posedge Clk);
    #2 Rst = 1'b0;

    // Requests held during the sweep must be ignored
    repeat (DPTH - 1) @(posedge Clk);
    #2;
    chk("busy_last", 32'(busy1), 32'h1);
    chk("init_nodv", 32'(dv1), 32'h0);
    @(posedge Clk); #2;
    chk("busy_done", 32'(busy1), 32'h0);
    chk("init_noerr", 32'(err1), 32'h0);
    WE = 1'b0; RD = 1'b0;
    sweep_zero();

    pv = 1'b0;
    pd = 32'h0;
    for (int i = 0; i < 20; i++) begin
      CS = 1'b1;
      WE = tbl[i].we; WAddr = tbl[i].wa; dataIn = tbl[i].di;
      BE = tbl[i].be; RD = tbl[i].rd; RAddr = tbl[i].ra;
      @(posedge Clk); #2;
      chk($sformatf("v%0d_dv1", i), 32'(dv1), 32'(tbl[i].ev));
      chk($sformatf("v%0d_do1", i), do1, tbl[i].ed);
      chk($sformatf("v%0d_err", i), 32'(err1), 32'(tbl[i].ee));
      chk($sformatf("v%0d_dv2", i), 32'(dv2), 32'(pv));
      chk($sformatf("v%0d_do2", i), do2, pd);
      pv = tbl[i].ev;
      pd = tbl[i].ed;
    end

    for (int i = 0; i < 400; i++) begin
      CS = ($urandom_range(0, 7) != 0);
      WE = $urandom_range(0, 1) == 1;
      RD = $urandom_range(0, 1) == 1;
      WAddr = 8'($urandom_range(0, 215));
      RAddr = ($urandom_range(0, 3) == 0) ? WAddr
                                          : 8'($urandom_range(0, 215));
      dataIn = $urandom;
      BE = 4'($urandom);
      @(posedge Clk); #2;
    end

    // Reset in the middle of a read burst
    CS = 1'b1; WE = 1'b0; RD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      RAddr = 8'($urandom_range(0, DPTH - 1));
      @(posedge Clk); #2;
    end
    Rst = 1'b1;
    #2;
    chk("mid_dv1", 32'(dv1), 32'h0);
    chk("mid_dv2", 32'(dv2), 32'h0);
    chk("mid_err", 32'(err1), 32'h0);
    chk("mid_busy", 32'(busy2), 32'h1);
    chk("mid_do2", do2, 32'h0);
    repeat (2) @(posedge Clk);
    #2 Rst = 1'b0;
    RAddr = 8'd5; WE = 1'b1; WAddr = 8'd9;
    repeat (DPTH) @(posedge Clk);
    #2;
    WE = 1'b0; RD = 1'b0;
    chk("re_busy", 32'(busy1), 32'h0);
    sweep_zero();

    repeat (2) @(posedge Clk);
    #4;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_ram_dp.md
# sync_ram_dp

Parametrised simple-dual-port synchronous SRAM, the successor to the single-port `syncRAM` in `synth/cptrie`. It provides one write port with byte enables and one independent read port, both active in the same cycle. It adds selectable read latency, write-first collision forwarding and a self-clearing init sweep after reset, plus a sticky out-of-range error flag. It is the lookup-table storage for the trie pipeline: one stage writes, one stage reads.

## Interface
Parameters:
- `ADR`, default 8: address width.
- `DAT`, default 32: data width; must be a multiple of 8.
- `DPTH`, default 192: number of words; must satisfy DPTH ≤ 2**ADR (non-power-of-two allowed).
- `RD_LAT`, default 1: read latency in cycles; legal values 1 or 2.

Ports (one clock; reset is asynchronous and active-high):
- `Clk`  in  1  clock, all state on rising edge.
- `Rst`  in  1  asynchronous active-high reset.
- `CS`  in  1  chip select; gates both ports.
- `WE`  in  1  write request.
- `WAddr`  in  ADR  write address.
- `dataIn`  in  DAT  write data.
- `BE`  in  DAT/8  byte enables; bit i covers dataIn[8i+7:8i].
- `RD`  in  1  read request.
- `RAddr`  in  ADR  read address.
- `dataOut`  out  DAT  read data.
- `dataValid`  out  1  dataOut carries a new read result this cycle.
- `Busy`  out  1  init sweep in progress; all requests ignored.
- `Err`  out  1  sticky: an accepted access used an address ≥ DPTH.

## Operation
- FSM states INIT and READY.
- Rst forces INIT with sweep counter 0. Rst asserted mid-sweep or mid-operation restarts the sweep from 0. Reset does not clear memory itself; the sweep does.
- INIT: each cycle write all-zero to mem[cnt], then cnt++. When cnt == DPTH-1 is written, go to READY on the next edge. Busy = (state == INIT).
- READY: a write is accepted when CS & WE. Bytes with BE[i]=1 are updated; the others are preserved. BE = 0 accepted means no change.
- READY: a read is accepted when CS & RD. Read and write may both be accepted in the same cycle; the old RD/WE mutual exclusion is gone.
- Collision (both accepted, RAddr == WAddr, address in range): write-first. The read returns the old word merged with dataIn on the enabled bytes.
- Out of range (address ≥ DPTH): the write is dropped; the read returns 0 with dataValid still asserted. Err is set and stays set until Rst.
- Requests during INIT (Busy=1) are fully ignored: no write, no dataValid, no Err.
- dataOut holds its last value when no read completes.

## Timing
- Reset values: dataOut = 0, dataValid = 0, Err = 0, Busy = 1.
- Busy stays high for exactly DPTH cycles after Rst deasserts. The first request is accepted in cycle DPTH+1 relative to deassertion.
- RD_LAT=1: a read accepted at edge n gives dataOut/dataValid after edge n+1, with dataValid high one cycle.
- RD_LAT=2: one extra output register stage. Results appear after edge n+2, and one read per cycle is still sustained.
- A write accepted at edge n is visible to a non-colliding read accepted at edge n+1.
- Err asserts after the same edge that accepts the offending request.
- Throughput: one read plus one write every cycle, no stalls in READY.

## Structure
- Package `sync_ram_pkg`: FSM state enum (INIT, READY) and a helper for the byte-enable merge mask.
- Sub-module `ram_rd_pipe`: RD_LAT-deep valid/data output pipeline, reset to zero.
- Memory array, sweep counter, FSM, collision merge and Err live in the top module.
- Elaboration-time checks: DAT % 8 == 0, DPTH ≤ 2**ADR, RD_LAT ∈ {1, 2}.

## Test plan
- Reset then init: release Rst and hold RD=1 at RAddr=5. Busy stays high for 192 cycles with no dataValid. After READY, reading 0..191 returns 0 for every word.
- Byte-enable write: write 0xAABBCCDD to addr 10 with BE=4'hF, then 0x11223344 with BE=4'b0101. Reading addr 10 returns 0xAA22CC44, one cycle later with RD_LAT=1.
- Collision: mem[20] = 0x0, then in one cycle WE (0xDEADBEEF, BE=4'b1100) and RD to addr 20. dataOut = 0xDEAD0000.
- Out of range: write 0x12345678 to addr 200, then read addr 200. dataOut = 0, dataValid = 1, and Err rises and stays high. Reading addr 0 is unaffected.
- Latency/throughput with RD_LAT=2: back-to-back reads of addrs 1, 2, 3 (preloaded 0x1, 0x2, 0x3) return 0x1, 0x2, 0x3 on three consecutive cycles, starting two cycles after the first request.
- Reset mid-operation: assert Rst during a read burst. dataValid = 0 and Err = 0 immediately, Busy = 1, the sweep restarts, and all words read 0 afterwards.
